// File: rtl/dmem_resp.sv
// Data memory response block: byte-writable word RAM plus a small MMIO window
// (free-running cycle counter and a scratch register) with a read-only debug port.
module dmem_resp #(
  parameter int          WORDS_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data
);

  localparam int WORDS = 1 << WORDS_LOG2;

  logic [31:0] mem_q [WORDS];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic [31:0] test_data_q, test_data_d;

  logic                  ram_we;
  logic                  scratch_we;
  logic [WORDS_LOG2-1:0] dm_idx;

  function automatic logic is_ram(input logic [31:0] a);
    return (a >> (WORDS_LOG2 + 2)) == 32'd0;
  endfunction

  function automatic logic is_mmio(input logic [31:0] a);
    return a[31:4] == MMIO_BASE[31:4];
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  wen);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (wen[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Reads use the pre-edge state, which gives read-first behaviour on both ports.
  function automatic logic [31:0] read_word(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (is_ram(a)) begin
      r = mem_q[a[WORDS_LOG2+1:2]];
    end else if (is_mmio(a)) begin
      case (a[3:2])
        2'd0:    r = cycle_q;
        2'd1:    r = scratch_q;
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  assign dm_idx     = dm_addr[WORDS_LOG2+1:2];
  assign ram_we     = !rst && is_ram(dm_addr) && (dm_wen != 4'd0);
  assign scratch_we = is_mmio(dm_addr) && !is_ram(dm_addr) && (dm_addr[3:2] == 2'd1);

  always_comb begin
    cycle_d     = cycle_q + 32'd1;
    scratch_d   = scratch_q;
    if (scratch_we) scratch_d = merge_lanes(scratch_q, dm_wdata, dm_wen);
    dm_rdata_d  = read_word(dm_addr);
    test_data_d = read_word(test_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= 32'd0;
      scratch_q   <= 32'd0;
      dm_rdata_q  <= 32'd0;
      test_data_q <= 32'd0;
    end else begin
      cycle_q     <= cycle_d;
      scratch_q   <= scratch_d;
      dm_rdata_q  <= dm_rdata_d;
      test_data_q <= test_data_d;
    end
  end

  // RAM contents survive reset; writes are simply suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (dm_wen[i]) mem_q[dm_idx][8*i +: 8] <= dm_wdata[8*i +: 8];
    end
  end

  assign dm_rdata  = dm_rdata_q;
  assign test_data = test_data_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: a byte-level reference model predicts every
// registered response; a monitor pops and compares one entry per clock.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [31:0] test_addr;
  logic [31:0] test_data;

  dmem_resp dut (
    .clk       (clk),
    .rst       (rst),
    .dm_addr   (dm_addr),
    .dm_wen    (dm_wen),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .test_addr (test_addr),
    .test_data (test_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dm;
    bit          dk;
    logic [31:0] t;
    bit          tk;
    bit          dce;
    logic [31:0] dcv;
    bit          tce;
    logic [31:0] tcv;
    string       nm;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: RAM bytes keyed by byte address, counter, scratch.
  logic [7:0]  mem_m [logic [31:0]];
  logic [31:0] cyc_m     = 32'd0;
  logic [31:0] scratch_m = 32'd0;

  function automatic logic [31:0] mread(input logic [31:0] a, output bit known);
    logic [31:0] v;
    logic [31:0] b;
    known = 1'b1;
    v = 32'd0;
    if (a < 32'h0000_1000) begin
      b = a & ~32'd3;
      for (int i = 0; i < 4; i++) begin
        if (mem_m.exists(b + i)) v[8*i +: 8] = mem_m[b + i];
        else known = 1'b0;
      end
    end else if (a >= 32'h0000_1000 && a < 32'h0000_1010) begin
      case ((a - 32'h0000_1000) >> 2)
        0:       v = cyc_m;
        1:       v = scratch_m;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input logic [31:0] ta,
                      input bit dce = 1'b0, input logic [31:0] dcv = 32'd0,
                      input bit tce = 1'b0, input logic [31:0] tcv = 32'd0,
                      input string nm = "rand");
    exp_t e;
    rst = r; dm_addr = a; dm_wen = w; dm_wdata = d; test_addr = ta;
    if (r) begin
      e.dm = 32'd0; e.dk = 1'b1; e.t = 32'd0; e.tk = 1'b1;
    end else begin
      e.dm = mread(a, e.dk);
      e.t  = mread(ta, e.tk);
    end
    e.dce = dce; e.dcv = dcv; e.tce = tce; e.tcv = tcv; e.nm = nm;
    sb.push_back(e);
    if (r) begin
      cyc_m = 32'd0;
      scratch_m = 32'd0;
    end else begin
      cyc_m = cyc_m + 32'd1;
      for (int i = 0; i < 4; i++) begin
        if (w[i]) begin
          if (a < 32'h0000_1000) mem_m[(a & ~32'd3) + i] = d[8*i +: 8];
          else if (a >= 32'h0000_1004 && a < 32'h0000_1008) scratch_m[8*i +: 8] = d[8*i +: 8];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: the DUT presents a response every cycle, one edge after the request.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dk)  check({e.nm, " dm_rdata"}, dm_rdata, e.dm);
        if (e.tk)  check({e.nm, " test_data"}, test_data, e.t);
        if (e.dce) check({e.nm, " dm_rdata const"}, dm_rdata, e.dcv);
        if (e.tce) check({e.nm, " test_data const"}, test_data, e.tcv);
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return 32'($urandom_range(0, 255));
    else if (r <= 7) return 32'h0000_1000 + 32'($urandom_range(0, 15));
    else if (r == 8) return 32'h0001_0000 + 32'($urandom_range(0, 255));
    else             return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [3:0] w;
    // Reset: outputs load zero.
    step(1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, "reset");
    step(1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, "reset");

    // Counter: post-reset edge k returns k; writes to CYCLE are ignored.
    for (int i = 0; i < 99; i++) step(1'b0, 32'h2000, 4'h0, 32'h0, 32'h0001_0000);
    step(1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 32'd99, 1'b0, 32'h0, "cycle99");
    step(1'b0, 32'h1000, 4'hF, 32'hDEAD, 32'h1000, 1'b1, 32'd100, 1'b1, 32'd100, "cycle_wr");
    step(1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 32'd101, 1'b0, 32'h0, "cycle_after_wr");

    // Counter wrap via backdoor.
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    cyc_m = 32'hFFFF_FFFE;
    step(1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, "wrap0");
    step(1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, "wrap1");
    step(1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, "wrap2");

    // Byte lane write.
    step(1'b0, 32'h10, 4'hF, 32'h1122_3344, 32'h0);
    step(1'b0, 32'h12, 4'b0100, 32'h00AB_0000, 32'h0);
    step(1'b0, 32'h10, 4'h0, 32'h0, 32'h0, 1'b1, 32'h11AB_3344, 1'b0, 32'h0, "byte_wr");

    // Read-first on the same word.
    step(1'b0, 32'h20, 4'hF, 32'hDEAD_BEEF, 32'h0);
    step(1'b0, 32'h20, 4'hF, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, "read_first_old");
    step(1'b0, 32'h20, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, "read_first_new");

    // Reset mid-operation: scratch clears, RAM keeps its word, write suppressed.
    step(1'b0, 32'h1004, 4'hF, 32'h5A5A_5A5A, 32'h0);
    step(1'b0, 32'h40, 4'hF, 32'hCAFE_F00D, 32'h0);
    step(1'b0, 32'h1004, 4'h0, 32'h0, 32'h1004, 1'b1, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A, "scratch");
    step(1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF, 32'h40, 1'b1, 32'h0, 1'b1, 32'h0, "mid_reset");
    step(1'b0, 32'h1004, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, "scratch_cleared");
    step(1'b0, 32'h40, 4'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, "ram_kept");

    // Unmapped region: reads zero, writes have no effect.
    step(1'b0, 32'h0, 4'hF, 32'h1357_9BDF, 32'h0);
    step(1'b0, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, "unmapped_wr");
    step(1'b0, 32'h0001_0000, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h1357_9BDF, "unmapped_rd");

    // MMIO reserved words.
    step(1'b0, 32'h1008, 4'hF, 32'h1234_5678, 32'h100C);
    step(1'b0, 32'h1008, 4'h0, 32'h0, 32'h100C, 1'b1, 32'h0, 1'b1, 32'h0, "mmio_rsvd");

    // Test port sees the pre-write word, then the new one.
    step(1'b0, 32'h10, 4'hF, 32'h1, 32'h10, 1'b1, 32'h11AB_3344, 1'b1, 32'h11AB_3344, "tport_old");
    step(1'b0, 32'h2000, 4'h0, 32'h0, 32'h10, 1'b0, 32'h0, 1'b1, 32'h1, "tport_new");

    // Preload the random window, then randomized traffic.
    for (int i = 0; i < 64; i++) step(1'b0, 32'(i * 4), 4'hF, $urandom, 32'(i * 4));
    for (int i = 0; i < 1500; i++) begin
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom_range(0, 49) == 0), rand_addr(), w, $urandom, rand_addr());
    end

    step(1'b0, 32'h2000, 4'h0, 32'h0, 32'h2000);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
